// File: rtl/ddr3_cache_pkg.sv
// Shared types and helpers for the DDR3 set-associative write-through cache.
package ddr3_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Way-index width; a direct-mapped cache still carries a 1-bit index.
  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/ddr3_assoc_cache_if.sv
// Client word port and DDR3 line port of ddr3_assoc_cache; slave = cache side.
interface ddr3_assoc_cache_if #(
  parameter int unsigned LINES_W    = 128,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned EXT_ADDR_W = 26
);
  localparam int unsigned WORDS  = LINES_W / DATA_W;
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned ADDR_W = EXT_ADDR_W + OFF_W;

  logic                  read_rq;
  logic                  write_rq;
  logic                  invalidate;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W-1:0]     read_data;
  logic                  finished;

  logic                  ext_read_rq;
  logic                  ext_write_rq;
  logic                  ext_rq_finished;
  logic [EXT_ADDR_W-1:0] ext_address;
  logic [LINES_W-1:0]    ext_write_data;
  logic [WORDS-1:0]      ext_write_mask;
  logic [LINES_W-1:0]    ext_read_data;

  modport slave (
    input  read_rq, write_rq, invalidate, address, write_data,
    input  ext_rq_finished, ext_read_data,
    output read_data, finished,
    output ext_read_rq, ext_write_rq, ext_address, ext_write_data, ext_write_mask
  );

  modport master (
    output read_rq, write_rq, invalidate, address, write_data,
    output ext_rq_finished, ext_read_data,
    input  read_data, finished,
    input  ext_read_rq, ext_write_rq, ext_address, ext_write_data, ext_write_mask
  );
endinterface

// File: rtl/ddr3_cache_tag_match.sv
// Combinational WAYS-wide tag compare with first-invalid / round-robin victim choice.
module ddr3_cache_tag_match #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned WAY_W = 2
) (
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [WAYS-1:0][TAG_W-1:0]  way_tags_i,
  input  logic [WAYS-1:0]             way_valid_i,
  input  logic [WAY_W-1:0]            rr_i,
  output logic                        hit_o,
  output logic [WAY_W-1:0]            hit_way_o,
  output logic [WAY_W-1:0]            victim_way_o
);

  always_comb begin
    hit_o        = 1'b0;
    hit_way_o    = '0;
    victim_way_o = rr_i;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_valid_i[w] && (way_tags_i[w] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
    end
    // Scan downwards so the lowest-numbered invalid way is the one left standing.
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!way_valid_i[w-1]) victim_way_o = WAY_W'(w - 1);
    end
  end

endmodule

// File: rtl/ddr3_assoc_cache.sv
// N-way set-associative write-through cache in front of a DDR3 line port.
// Optional hit/miss counters: define CACHE_STATS_EN.
module ddr3_assoc_cache
  import ddr3_cache_pkg::*;
#(
  parameter int unsigned LINES_W    = 128,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SET_W      = 6,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned EXT_ADDR_W = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  ddr3_assoc_cache_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses
`endif
);

  localparam int unsigned WORDS  = LINES_W / DATA_W;
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned ADDR_W = EXT_ADDR_W + OFF_W;
  localparam int unsigned TAG_W  = EXT_ADDR_W - SET_W;
  localparam int unsigned SETS   = 2 ** SET_W;
  localparam int unsigned WAY_W  = way_bits(WAYS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                is_wr_q, is_wr_d;

  logic [WAYS-1:0][SETS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;
  logic [LINES_W-1:0]         data_mem [WAYS][SETS];
  logic [TAG_W-1:0]           tag_mem  [WAYS][SETS];

  logic [SET_W-1:0]           set_idx;
  logic [TAG_W-1:0]           tag;
  logic [OFF_W-1:0]           off;
  logic [WAYS-1:0][TAG_W-1:0] way_tags;
  logic [WAYS-1:0]            way_valid;
  logic                       hit;
  logic [WAY_W-1:0]           hit_way, victim_way;
  logic [LINES_W-1:0]         hit_line;
  logic                       inv, fill_we, hit_we, stat_hit, stat_miss;

  assign set_idx  = addr_q[OFF_W +: SET_W];
  assign tag      = addr_q[ADDR_W-1 -: TAG_W];
  assign off      = addr_q[OFF_W-1:0];
  assign hit_line = data_mem[hit_way][set_idx];

  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_tags[w]  = tag_mem[w][set_idx];
      way_valid[w] = valid_q[w][set_idx];
    end
  end

  ddr3_cache_tag_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_match (
    .tag_i        (tag),
    .way_tags_i   (way_tags),
    .way_valid_i  (way_valid),
    .rr_i         (rr_q[set_idx]),
    .hit_o        (hit),
    .hit_way_o    (hit_way),
    .victim_way_o (victim_way)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_wr_d   = is_wr_q;
    inv       = 1'b0;
    fill_we   = 1'b0;
    hit_we    = 1'b0;
    stat_hit  = 1'b0;
    stat_miss = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.invalidate) begin
          inv = 1'b1;
        end else if (bus.write_rq) begin
          addr_d  = bus.address;
          wdata_d = bus.write_data;
          is_wr_d = 1'b1;
          state_d = ST_LOOKUP;
        end else if (bus.read_rq) begin
          addr_d  = bus.address;
          is_wr_d = 1'b0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (is_wr_q) begin
          hit_we  = hit;
          state_d = ST_WRITE;
        end else if (hit) begin
          rdata_d  = hit_line[off*DATA_W +: DATA_W];
          stat_hit = 1'b1;
          state_d  = ST_RESP;
        end else begin
          stat_miss = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.ext_rq_finished) begin
          fill_we = 1'b1;
          rdata_d = bus.ext_read_data[off*DATA_W +: DATA_W];
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        if (bus.ext_rq_finished) state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
      if (inv) begin
        valid_q <= '0;
      end else if (fill_we) begin
        valid_q[victim_way][set_idx] <= 1'b1;
        rr_q[set_idx] <= (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;
      end
    end
  end

  // Line and tag storage carry no reset; the valid flops qualify every read.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[victim_way][set_idx] <= bus.ext_read_data;
      tag_mem[victim_way][set_idx]  <= tag;
    end else if (hit_we) begin
      data_mem[hit_way][set_idx][off*DATA_W +: DATA_W] <= wdata_q;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (inv) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (stat_hit && (stat_hits != '1))     stat_hits   <= stat_hits + 32'd1;
      if (stat_miss && (stat_misses != '1))  stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

  assign bus.finished       = (state_q == ST_RESP);
  assign bus.read_data      = (state_q == ST_RESP && !is_wr_q) ? rdata_q : '0;
  assign bus.ext_read_rq    = (state_q == ST_FILL);
  assign bus.ext_write_rq   = (state_q == ST_WRITE);
  assign bus.ext_address    = addr_q[ADDR_W-1:OFF_W];
  assign bus.ext_write_data = {WORDS{wdata_q}};
  assign bus.ext_write_mask = (state_q == ST_WRITE) ? (WORDS'(1) << off) : '0;

endmodule

// File: tb/tb_ddr3_assoc_cache.sv
// Directed self-checking bench for ddr3_assoc_cache (default geometry, 16 words per line).
module tb_ddr3_assoc_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr3_assoc_cache_if #(.LINES_W(128), .DATA_W(8), .EXT_ADDR_W(26)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
  int unsigned sb_hits = 0, sb_misses = 0;
`endif

  ddr3_assoc_cache #(
    .LINES_W(128), .DATA_W(8), .SET_W(6), .WAYS(4), .EXT_ADDR_W(26)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line whose byte i holds base+i.
  function automatic logic [127:0] mk_line(input logic [7:0] base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  bit             saw_rd, saw_wr, both;
  logic [25:0]    xaddr;
  logic [15:0]    xmask;
  logic [127:0]   xdata;
  logic [7:0]     rd;
  int             cyc;

  // One client transaction; the ext side answers lat cycles after a request appears.
  task automatic run_op(input bit is_wr, input logic [29:0] addr, input logic [7:0] wd,
                        input logic [127:0] line, input int lat);
    bit done = 0;
    int waitc = 0;
    saw_rd = 0; saw_wr = 0; both = 0; xaddr = '0; xmask = '0; xdata = '0; rd = '0; cyc = 0;
    @(negedge clk);
    bus.address    = addr;
    bus.write_data = wd;
    if (is_wr) bus.write_rq = 1'b1; else bus.read_rq = 1'b1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus.ext_rq_finished = 1'b0;
      if (bus.ext_read_rq && bus.ext_write_rq) both = 1;
      if (bus.finished) begin
        rd = bus.read_data;
        done = 1;
      end else if (bus.ext_read_rq || bus.ext_write_rq) begin
        saw_rd |= bus.ext_read_rq;
        saw_wr |= bus.ext_write_rq;
        xaddr = bus.ext_address;
        xmask = bus.ext_write_mask;
        xdata = bus.ext_write_data;
        if (waitc < lat) waitc++;
        else begin
          bus.ext_read_data   = line;
          bus.ext_rq_finished = 1'b1;
        end
      end
    end
    bus.read_rq  = 1'b0;
    bus.write_rq = 1'b0;
    chk("done_in_budget", 128'(done), 128'd1);
    chk("rd_wr_exclusive", 128'(both), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [29:0] addr, input logic [127:0] line,
                        input bit miss, input logic [7:0] exp, input int lat);
    run_op(1'b0, addr, 8'h00, line, lat);
    chk({tag, "_miss"}, 128'(saw_rd), 128'(miss));
    chk({tag, "_data"}, 128'(rd), 128'(exp));
    chk({tag, "_cycles"}, 128'(cyc), miss ? 128'(3 + lat) : 128'd2);
    if (miss) chk({tag, "_ext_addr"}, 128'(xaddr), 128'(addr[29:4]));
`ifdef CACHE_STATS_EN
    if (miss) sb_misses++; else sb_hits++;
`endif
  endtask

  task automatic wr_chk(input string tag, input logic [29:0] addr, input logic [7:0] wd,
                        input int lat);
    run_op(1'b1, addr, wd, '0, lat);
    chk({tag, "_ext_wr"}, 128'({saw_wr, saw_rd}), 128'b10);
    chk({tag, "_ext_addr"}, 128'(xaddr), 128'(addr[29:4]));
    chk({tag, "_mask"}, 128'(xmask), 128'(16'h1 << addr[3:0]));
    chk({tag, "_wdata"}, xdata, {16{wd}});
    chk({tag, "_rdata_zero"}, 128'(rd), 128'd0);
    chk({tag, "_cycles"}, 128'(cyc), 128'(3 + lat));
  endtask

`ifdef CACHE_STATS_EN
  task automatic stat_chk(input string tag);
    chk({tag, "_hits"}, 128'(stat_hits), 128'(sb_hits));
    chk({tag, "_misses"}, 128'(stat_misses), 128'(sb_misses));
  endtask
`endif

  initial begin
    bus.read_rq = 0; bus.write_rq = 0; bus.invalidate = 0;
    bus.address = '0; bus.write_data = '0;
    bus.ext_rq_finished = 0; bus.ext_read_data = '0;

    #12;
    chk("reset_ctl", 128'({bus.finished, bus.ext_read_rq, bus.ext_write_rq}), 128'd0);
    chk("reset_bus", 128'({bus.read_data, bus.ext_address, bus.ext_write_mask}), 128'd0);
    chk("reset_wdata", bus.ext_write_data, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill then hit
    rd_chk("t1_fill", 30'h0000123, 128'h0F0E0D0C0B0A09080706050403020100, 1, 8'h03, 2);
    rd_chk("t1_hit", 30'h0000123, '0, 0, 8'h03, 0);
    rd_chk("t1_hit_top", 30'h000012F, '0, 0, 8'h0F, 0);

    // 2: write-through hit, write miss no-allocate
    wr_chk("t2_wr_hit", 30'h0000125, 8'hAA, 1);
    rd_chk("t2_rd_upd", 30'h0000125, '0, 0, 8'hAA, 0);
    rd_chk("t2_rd_nbr", 30'h0000124, '0, 0, 8'h04, 0);
    wr_chk("t2_wr_miss", 30'h4000000, 8'h55, 0);
    rd_chk("t2_rd_after_wmiss", 30'h4000000, mk_line(8'h80), 1, 8'h80, 0);

    // 3: set 0x12 holds tag0 in way0; tags 1..4 fill, tag4 evicts tag0
    rd_chk("t3_tag1", 30'h0000520, mk_line(8'h10), 1, 8'h10, 0);
    rd_chk("t3_tag2", 30'h0000920, mk_line(8'h20), 1, 8'h20, 0);
    rd_chk("t3_tag3", 30'h0000D20, mk_line(8'h30), 1, 8'h30, 0);
    rd_chk("t3_tag4", 30'h0001120, mk_line(8'h40), 1, 8'h40, 0);
    rd_chk("t3_tag1_hit", 30'h0000523, '0, 0, 8'h13, 0);
    rd_chk("t3_tag4_hit", 30'h0001120, '0, 0, 8'h40, 0);
    rd_chk("t3_tag0_evicted", 30'h0000121, mk_line(8'h50), 1, 8'h51, 0);
    rd_chk("t3_tag1_evicted", 30'h0000520, mk_line(8'h60), 1, 8'h60, 0);
`ifdef CACHE_STATS_EN
    stat_chk("t6_stats");
`endif

    // 4: invalidate, stray ext_rq_finished in IDLE
    @(negedge clk); bus.invalidate = 1'b1;
    @(posedge clk); #1;
    chk("t4_inv_no_finish", 128'(bus.finished), 128'd0);
    bus.invalidate = 1'b0;
`ifdef CACHE_STATS_EN
    sb_hits = 0; sb_misses = 0;
    stat_chk("t4_stats_clr");
`endif
    @(negedge clk); bus.ext_rq_finished = 1'b1;
    @(posedge clk); #1;
    bus.ext_rq_finished = 1'b0;
    chk("t4_stray_ignored", 128'({bus.finished, bus.ext_read_rq, bus.ext_write_rq}), 128'd0);
    rd_chk("t4_after_inv", 30'h0000123, mk_line(8'h00), 1, 8'h03, 0);

    // 5: reset mid FILL
    begin
      int n = 0;
      @(negedge clk); bus.address = 30'h0002340; bus.read_rq = 1'b1;
      while (!bus.ext_read_rq && n < 20) begin @(posedge clk); #1; n++; end
      chk("t5_reached_fill", 128'(bus.ext_read_rq), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_abort_ctl", 128'({bus.ext_read_rq, bus.finished}), 128'd0);
      bus.read_rq = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
    end
`ifdef CACHE_STATS_EN
    sb_hits = 0; sb_misses = 0;
    stat_chk("t5_stats_rst");
`endif
    rd_chk("t5_refetch", 30'h0002340, mk_line(8'h70), 1, 8'h70, 0);
    rd_chk("t5_cold_again", 30'h0000123, mk_line(8'h00), 1, 8'h03, 0);
    rd_chk("t5_hit", 30'h0002340, '0, 0, 8'h70, 0);
`ifdef CACHE_STATS_EN
    stat_chk("t5_stats_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
